bus_arb: RTL
============

Name: bus_arb

Overview:
Two-master arbiter for the 16 MB word-addressed system bus (stb/we/addr/dout/din/ack, ack-terminated).
- Master 0 is the CPU.
- Master 1 is a second bus master, e.g. a DMA/blitter engine for RAM and HCV memory.
- Sits between the masters and the address decoder; the decoder sees a single bus_* master.
- Provides round-robin fairness and a no-ack timeout so a hung or unmapped slave cannot stall the system.

Parameters:
TIMEOUT, 1023, cycles a granted transfer may wait for bus_ack before the arbiter terminates it (legal range 2..65535).
CW, 16, width of the timeout counter (2**CW-1 must be >= TIMEOUT).

Ports:
clk  input  1  system clock (50 MHz domain); all logic on rising edge
rst  input  1  synchronous reset, active-high
m0_stb  input  1  master 0 request; held until m0_ack
m0_we  input  1  master 0 write enable
m0_addr  input  22  master 0 word address [23:2]
m0_dout  input  32  master 0 write data
m0_din  output  32  master 0 read data
m0_ack  output  1  master 0 acknowledge
m1_stb, m1_we, m1_addr, m1_dout, m1_din, m1_ack  same as master 0, for master 1
bus_stb  output  1  strobe to address decoder
bus_we  output  1  write enable to bus
bus_addr  output  22  word address [23:2] to bus
bus_dout  output  32  write data to bus
bus_din  input  32  read data from bus mux
bus_ack  input  1  acknowledge from bus mux (may be combinational in the same cycle as bus_stb)
grant  output  2  one-hot current grant {m1,m0}; 2'b00 when idle
to_err  output  1  one-cycle pulse when a transfer is timed out

Behaviour:
- Handshake rule: a transfer completes in the cycle where the master's stb=1 and its ack=1. A master keeps stb, we, addr and dout stable until then.
- State machine: IDLE, GNT0, GNT1 (registered). Reset → IDLE, last=1 (so master 0 wins the first tie), timeout counter cnt=0.
- IDLE:
  - only m0_stb → GNT0
  - only m1_stb → GNT1
  - both → the master that is not `last`
  - none → stay IDLE
  - This gives one cycle of arbitration latency; no request is forwarded in the IDLE cycle.
- On entry to GNTx: cnt cleared, last <= x.
- Bus routing in GNTx:
  - bus_stb = mx_stb; bus_we, bus_addr and bus_dout come from master x.
  - mx_ack = bus_ack; mx_din = bus_din.
  - The other master's ack=0 and din=0.
- Bus outputs in IDLE: bus_stb=0, bus_we=0, bus_addr=0, bus_dout=0; both acks 0, both din 0, grant=00.
- Exits from GNTx:
  - bus_ack=1 and mx_stb=1 → IDLE next cycle. Grant is released after every transfer, so back-to-back requests cost 1 idle cycle.
  - mx_stb drops without ack (protocol violation) → IDLE, no ack, no error.
  - Timeout: cnt increments each GNTx cycle without ack. When cnt==TIMEOUT-1 and still no ack:
    - mx_ack=1 and mx_din=32'h0 (combinationally, this cycle);
    - bus_stb forced 0 this cycle;
    - to_err=1 for this cycle only;
    - → IDLE.
  - Ack and timeout in the same cycle: the real ack wins (bus_din passed through, to_err=0).
- Round-robin: with both masters continuously requesting, grants alternate 0,1,0,1. A single requester is granted every other cycle pair, never starved.
- A request arriving on the other master during GNTx waits; it is granted from IDLE after the current transfer.
- rst mid-transfer: next cycle is IDLE, bus_stb=0, all acks 0, to_err=0, last=1. The interrupted transfer is dropped without ack.
- Reset values: bus_stb=0, bus_we=0, bus_addr=0, bus_dout=0, m0_ack=m1_ack=0, m0_din=m1_din=0, grant=00, to_err=0.
- No combinational path from bus_ack to bus_stb, except the timeout suppression, which depends only on registered cnt.

Test Plan:
- m0 read of 0xFFE000 (m0_addr=22'h3FF800), slave acks in the same cycle with bus_din=32'h12345678 → grant=01 one cycle after m0_stb, m0_ack=1 and m0_din=32'h12345678 in that cycle, IDLE next cycle.
- m0 and m1 assert stb in the same cycle after reset, each ack after 2 cycles → m0 served first, then m1. Repeat with both held → grant sequence 01,00,10,00,01.
- m1 write, addr 22'h300000, dout 32'hCAFEBABE, RAM acks after 5 cycles → bus_stb=1 for exactly 5 cycles with m1 fields on bus; m0_ack stays 0 throughout.
- TIMEOUT=8, m0 access to an unmapped address, bus_ack never asserted → m0_ack=1 and m0_din=0 in the 8th granted cycle, to_err pulses once, bus_stb=0 in that cycle.
- rst asserted on cycle 3 of a pending m1 transfer → next cycle bus_stb=0, grant=00, no m1_ack. A subsequent tie grants m0.
- m1 drops stb after 2 granted cycles without ack → IDLE next cycle, to_err=0, m0 request pending is granted the following cycle.

Source files
------------

// File: rtl/bus_arb.sv
// Two-master round-robin arbiter for the word-addressed system bus.
// Grant is released after every transfer; a no-ack timeout terminates hung accesses.
module bus_arb #(
   parameter int unsigned TIMEOUT = 1023,
   parameter int unsigned CW      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_stb,
   input  logic        m0_we,
   input  logic [21:0] m0_addr,
   input  logic [31:0] m0_dout,
   output logic [31:0] m0_din,
   output logic        m0_ack,
   input  logic        m1_stb,
   input  logic        m1_we,
   input  logic [21:0] m1_addr,
   input  logic [31:0] m1_dout,
   output logic [31:0] m1_din,
   output logic        m1_ack,
   output logic        bus_stb,
   output logic        bus_we,
   output logic [21:0] bus_addr,
   output logic [31:0] bus_dout,
   input  logic [31:0] bus_din,
   input  logic        bus_ack,
   output logic [1:0]  grant,
   output logic        to_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_last;
   logic [CW-1:0]   r_cnt;

   logic            w_gnt;
   logic            w_m1;
   logic            w_stb;
   logic            w_we;
   logic [21:0]     w_addr;
   logic [31:0]     w_dout;
   logic            w_hit;
   logic            w_to;
   logic            w_ack;
   logic [31:0]     w_din;

   assign w_gnt  = (r_state != IDLE);
   assign w_m1   = (r_state == GNT1);
   assign w_stb  = w_m1 ? m1_stb  : m0_stb;
   assign w_we   = w_m1 ? m1_we   : m0_we;
   assign w_addr = w_m1 ? m1_addr : m0_addr;
   assign w_dout = w_m1 ? m1_dout : m0_dout;
   // Strobe suppression uses only the registered count, keeping bus_ack out of bus_stb.
   assign w_hit  = (r_cnt == CW'(TIMEOUT - 1));
   assign w_to   = w_gnt & w_stb & w_hit & ~bus_ack;
   assign w_ack  = w_gnt & (bus_ack | w_to);
   assign w_din  = (w_gnt & ~w_to) ? bus_din : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == IDLE) ? '0 : r_cnt + 1'b1;
         if (r_state == IDLE && w_next == GNT0) r_last <= 1'b0;
         if (r_state == IDLE && w_next == GNT1) r_last <= 1'b1;
      end
   end

   always_comb begin
      w_next   = r_state;
      bus_stb  = 1'b0;
      bus_we   = 1'b0;
      bus_addr = '0;
      bus_dout = '0;
      m0_ack   = 1'b0;
      m1_ack   = 1'b0;
      m0_din   = '0;
      m1_din   = '0;
      grant    = 2'b00;
      to_err   = w_to;
      case (r_state)
         IDLE: begin
            if (m0_stb && m1_stb) w_next = r_last ? GNT0 : GNT1;
            else if (m0_stb)      w_next = GNT0;
            else if (m1_stb)      w_next = GNT1;
         end
         GNT0, GNT1: begin
            bus_stb  = w_stb & ~w_hit;
            bus_we   = w_we;
            bus_addr = w_addr;
            bus_dout = w_dout;
            grant    = w_m1 ? 2'b10 : 2'b01;
            m0_ack   = w_ack & ~w_m1;
            m1_ack   = w_ack & w_m1;
            m0_din   = w_m1 ? '0 : w_din;
            m1_din   = w_m1 ? w_din : '0;
            if (!w_stb || bus_ack || w_hit) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

endmodule
